fifo_sync: RTL and testbench

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_sync.sv | 80 ++++++++
 tb/tb_fifo_sync.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO with valid/ack handshakes on both sides.
// Storage, pointers and count are registered; data_o reads the entry at the read pointer.
module fifo_sync #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    rdy_i,
  output logic                    ack_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    rdy_o,
  input  logic                    ack_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  push;
  logic                  pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign ack_o   = !full_o && !flush_i;
  assign rdy_o   = !empty_o && !flush_i;
  assign push    = rdy_i && ack_o;
  assign pop     = rdy_o && ack_i;
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: storage is reset too, so data_o shows RST_VAL the moment rst_ni falls;
  // this keeps the array in flops rather than a RAM macro.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_VAL;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so push/pop decisions and pointer updates never race each other.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Handshake gating makes these unreachable; they guard against future edits.
  a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full_o && !pop));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty_o));
  a_count_range:  assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= FULL_CNT);

endmodule

// File: tb/tb_fifo_sync.sv
// Scenario bench for fifo_sync (DEPTH=4, 32-bit): a queue model predicts handshakes,
// count and head data; each scenario task compares DUT outputs against it.
module tb_fifo_sync;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic [DW-1:0] data_i;
  logic          rdy_i;
  logic          ack_o;
  logic [DW-1:0] data_o;
  logic          rdy_o;
  logic          ack_i;
  logic [2:0]    count_o;
  logic          full_o;
  logic          empty_o;

  fifo_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RST_VAL('0)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .data_i  (data_i),
    .rdy_i   (rdy_i),
    .ack_o   (ack_o),
    .data_o  (data_o),
    .rdy_o   (rdy_o),
    .ack_i   (ack_i),
    .count_o (count_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  always #5 clk_i = ~clk_i;

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] sb[$];

  logic          obs_ack, obs_rdy, obs_full, obs_empty;
  logic [DW-1:0] obs_data;
  logic [2:0]    obs_count;
  logic          exp_ack, exp_rdy, exp_full, exp_empty, have_head;
  logic [DW-1:0] exp_head;
  logic [2:0]    exp_count;

  // One cycle: drive at the falling edge, capture outputs 1ns later, predict from the
  // model, then apply the predicted push/pop/flush to the model at the rising edge.
  task automatic step(input logic rdy, input logic [DW-1:0] d, input logic ack, input logic flush);
    logic do_push, do_pop;
    @(negedge clk_i);
    rdy_i = rdy; data_i = d; ack_i = ack; flush_i = flush;
    #1;
    obs_ack = ack_o; obs_rdy = rdy_o; obs_data = data_o;
    obs_count = count_o; obs_full = full_o; obs_empty = empty_o;
    exp_count = 3'(sb.size());
    exp_full  = (sb.size() == DEPTH);
    exp_empty = (sb.size() == 0);
    exp_ack   = !exp_full && !flush;
    exp_rdy   = !exp_empty && !flush;
    have_head = !exp_empty;
    exp_head  = have_head ? sb[0] : '0;
    do_push   = rdy && exp_ack;
    do_pop    = ack && exp_rdy;
    @(posedge clk_i);
    if (flush) sb.delete();
    else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(d);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b1; flush_i = 1'b0; rdy_i = 1'b0; ack_i = 1'b0; data_i = '0;
    #1 rst_ni = 1'b0;
    #1;
    total += 6;
    if (rdy_o !== 1'b0)   begin bad++; $display("FAIL reset rdy_o got=%b want=0", rdy_o); end
    if (empty_o !== 1'b1) begin bad++; $display("FAIL reset empty_o got=%b want=1", empty_o); end
    if (full_o !== 1'b0)  begin bad++; $display("FAIL reset full_o got=%b want=0", full_o); end
    if (ack_o !== 1'b1)   begin bad++; $display("FAIL reset ack_o got=%b want=1", ack_o); end
    if (count_o !== 3'd0) begin bad++; $display("FAIL reset count_o got=%0d want=0", count_o); end
    if (data_o !== '0)    begin bad++; $display("FAIL reset data_o got=%h want=0", data_o); end
    sb.delete();
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, DW'(32'hA0 + i), 1'b0, 1'b0);
      total += 5;
      if (obs_ack !== exp_ack)     begin bad++; $display("FAIL fill ack_o i=%0d got=%b want=%b", i, obs_ack, exp_ack); end
      if (obs_rdy !== exp_rdy)     begin bad++; $display("FAIL fill rdy_o i=%0d got=%b want=%b", i, obs_rdy, exp_rdy); end
      if (obs_count !== exp_count) begin bad++; $display("FAIL fill count_o i=%0d got=%0d want=%0d", i, obs_count, exp_count); end
      if (obs_full !== exp_full)   begin bad++; $display("FAIL fill full_o i=%0d got=%b want=%b", i, obs_full, exp_full); end
      if (obs_empty !== exp_empty) begin bad++; $display("FAIL fill empty_o i=%0d got=%b want=%b", i, obs_empty, exp_empty); end
      if (have_head) begin
        total++;
        if (obs_data !== exp_head) begin bad++; $display("FAIL fill data_o i=%0d got=%h want=%h", i, obs_data, exp_head); end
      end
    end
    total += 3;
    if (obs_count !== 3'd4) begin bad++; $display("FAIL fill_full count_o got=%0d want=4", obs_count); end
    if (obs_full !== 1'b1)  begin bad++; $display("FAIL fill_full full_o got=%b want=1", obs_full); end
    if (obs_ack !== 1'b0)   begin bad++; $display("FAIL fill_full ack_o got=%b want=0", obs_ack); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      total += 4;
      if (obs_ack !== exp_ack)     begin bad++; $display("FAIL drain ack_o i=%0d got=%b want=%b", i, obs_ack, exp_ack); end
      if (obs_rdy !== exp_rdy)     begin bad++; $display("FAIL drain rdy_o i=%0d got=%b want=%b", i, obs_rdy, exp_rdy); end
      if (obs_count !== exp_count) begin bad++; $display("FAIL drain count_o i=%0d got=%0d want=%0d", i, obs_count, exp_count); end
      if (obs_empty !== exp_empty) begin bad++; $display("FAIL drain empty_o i=%0d got=%b want=%b", i, obs_empty, exp_empty); end
      if (i < 4) begin
        total++;
        if (obs_data !== DW'(32'hA0 + i)) begin bad++; $display("FAIL drain data_o i=%0d got=%h want=%h", i, obs_data, 32'hA0 + i); end
      end
    end
    total += 2;
    if (obs_empty !== 1'b1) begin bad++; $display("FAIL drain_end empty_o got=%b want=1", obs_empty); end
    if (obs_rdy !== 1'b0)   begin bad++; $display("FAIL drain_end rdy_o got=%b want=0", obs_rdy); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++) begin
      step(i < 16, DW'(i), 1'b1, 1'b0);
      total += 3;
      if (obs_ack !== exp_ack)     begin bad++; $display("FAIL b2b ack_o i=%0d got=%b want=%b", i, obs_ack, exp_ack); end
      if (obs_rdy !== exp_rdy)     begin bad++; $display("FAIL b2b rdy_o i=%0d got=%b want=%b", i, obs_rdy, exp_rdy); end
      if (obs_count !== exp_count) begin bad++; $display("FAIL b2b count_o i=%0d got=%0d want=%0d", i, obs_count, exp_count); end
      if (i > 0) begin
        total += 2;
        if (obs_count !== 3'd1)        begin bad++; $display("FAIL b2b hold count_o i=%0d got=%0d want=1", i, obs_count); end
        if (obs_data !== DW'(i - 1))   begin bad++; $display("FAIL b2b data_o i=%0d got=%h want=%h", i, obs_data, i - 1); end
      end
    end
  endtask

  task automatic test_flush();
    step(1'b1, DW'(32'h11), 1'b0, 1'b0);
    step(1'b1, DW'(32'h22), 1'b0, 1'b0);
    step(1'b1, DW'(32'h33), 1'b0, 1'b1);
    total += 2;
    if (obs_ack !== 1'b0) begin bad++; $display("FAIL flush ack_o got=%b want=0", obs_ack); end
    if (obs_rdy !== 1'b0) begin bad++; $display("FAIL flush rdy_o got=%b want=0", obs_rdy); end
    step(1'b0, '0, 1'b1, 1'b0);
    total += 3;
    if (obs_count !== 3'd0) begin bad++; $display("FAIL flush_after count_o got=%0d want=0", obs_count); end
    if (obs_empty !== 1'b1) begin bad++; $display("FAIL flush_after empty_o got=%b want=1", obs_empty); end
    if (obs_rdy !== 1'b0)   begin bad++; $display("FAIL flush_after rdy_o got=%b want=0", obs_rdy); end
    step(1'b1, DW'(32'h44), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    total += 2;
    if (obs_rdy !== 1'b1)          begin bad++; $display("FAIL flush_next rdy_o got=%b want=1", obs_rdy); end
    if (obs_data !== DW'(32'h44))  begin bad++; $display("FAIL flush_next data_o got=%h want=44", obs_data); end
    step(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (obs_empty !== 1'b1) begin bad++; $display("FAIL flush_end empty_o got=%b want=1", obs_empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h61 + i), 1'b0, 1'b0);
    @(negedge clk_i);
    rdy_i = 1'b0; ack_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    total += 4;
    if (rdy_o !== 1'b0)   begin bad++; $display("FAIL rst_mid rdy_o got=%b want=0", rdy_o); end
    if (data_o !== '0)    begin bad++; $display("FAIL rst_mid data_o got=%h want=0", data_o); end
    if (count_o !== 3'd0) begin bad++; $display("FAIL rst_mid count_o got=%0d want=0", count_o); end
    if (ack_o !== 1'b1)   begin bad++; $display("FAIL rst_mid ack_o got=%b want=1", ack_o); end
    sb.delete();
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    step(1'b1, DW'(32'h55), 1'b0, 1'b0);
    total++;
    if (obs_ack !== 1'b1) begin bad++; $display("FAIL rst_mid first_push ack_o got=%b want=1", obs_ack); end
    step(1'b0, '0, 1'b1, 1'b0);
    total += 3;
    if (obs_rdy !== 1'b1)         begin bad++; $display("FAIL rst_mid_after rdy_o got=%b want=1", obs_rdy); end
    if (obs_data !== DW'(32'h55)) begin bad++; $display("FAIL rst_mid_after data_o got=%h want=55", obs_data); end
    if (obs_count !== 3'd1)       begin bad++; $display("FAIL rst_mid_after count_o got=%0d want=1", obs_count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      total += 5;
      if (obs_ack !== exp_ack)     begin bad++; $display("FAIL rand ack_o i=%0d got=%b want=%b", i, obs_ack, exp_ack); end
      if (obs_rdy !== exp_rdy)     begin bad++; $display("FAIL rand rdy_o i=%0d got=%b want=%b", i, obs_rdy, exp_rdy); end
      if (obs_count !== exp_count) begin bad++; $display("FAIL rand count_o i=%0d got=%0d want=%0d", i, obs_count, exp_count); end
      if (obs_full !== exp_full)   begin bad++; $display("FAIL rand full_o i=%0d got=%b want=%b", i, obs_full, exp_full); end
      if (obs_empty !== exp_empty) begin bad++; $display("FAIL rand empty_o i=%0d got=%b want=%b", i, obs_empty, exp_empty); end
      if (have_head) begin
        total++;
        if (obs_data !== exp_head) begin bad++; $display("FAIL rand data_o i=%0d got=%h want=%h", i, obs_data, exp_head); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
